// File: rtl/filter_test_seq_pkg.sv
// Shared types and defaults for the filter test sequencer.
//   test_cfg_t  : one table entry driven onto the generator test inputs
//   seq_state_t : sequencer FSM states
//   SIZE_DELAY / SIZE_FILTER_DATA : generator delay width, filter sample width
//   FILTER_SEQ_SETTLE / FILTER_SEQ_MEASURE : default window lengths in cycles
package filter_test_seq_pkg;

  localparam int SIZE_DELAY         = 8;
  localparam int SIZE_FILTER_DATA   = 16;
  localparam int FILTER_SEQ_STEPS   = 8;
  localparam int FILTER_SEQ_SETTLE  = 64;
  localparam int FILTER_SEQ_MEASURE = 256;

  // Field order matches the wr_data packing {overlay, rate, delay}.
  typedef struct packed {
    logic                  overlay;
    logic                  rate;
    logic [SIZE_DELAY-1:0] delay;
  } test_cfg_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/filter_test_seq_if.sv
// Result handshake between the sequencer and whoever collects peak results.
//   res_valid : result available (sequencer -> collector)
//   res_ready : collector accepts the result
//   res_step  : table step the result belongs to
//   res_peak  : signed maximum observed over the measure window
interface filter_test_seq_if
  import filter_test_seq_pkg::*;
#(
  parameter int STEP_W = 3,
  parameter int DATA_W = SIZE_FILTER_DATA
) ();

  logic                     res_valid;
  logic                     res_ready;
  logic [STEP_W-1:0]        res_step;
  logic signed [DATA_W-1:0] res_peak;

  modport master (output res_valid, output res_step, output res_peak, input res_ready);
  modport slave  (input res_valid, input res_step, input res_peak, output res_ready);

endinterface

// File: rtl/filter_seq_peak.sv
// Signed running-maximum accumulator.
//   clk, reset : clock, asynchronous active-low reset (peak resets to 0)
//   clr_i      : preset peak to the most negative representable value
//   en_i       : fold data_i into the running maximum (clr_i wins)
//   data_i     : signed sample
//   peak_o     : current signed maximum
module filter_seq_peak #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic signed [DATA_W-1:0] peak_o
);

  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] peak_q, peak_d;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    peak_d = peak_q;
    if (clr_i) begin
      peak_d = MOST_NEG;
    end else if (en_i && (data_i > peak_q)) begin
      peak_d = data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;

endmodule

// File: rtl/filter_test_seq.sv
// Filter test sequencer: steps the signal generator through a table of test
// configurations, settles, measures the signed peak of a selected filter
// output and reports each peak over a valid/ready handshake.
//   clk, reset        : clock, asynchronous active-low reset
//   wr_en/addr/data   : table write port, honoured only while idle
//   start, run_steps  : begin a run of run_steps entries (1..NUM_STEPS)
//   abort             : end the current run immediately
//   filter_sel        : 1..6 selects output v1..v6, anything else v1
//   filter_data       : packed v6..v1 signed filter outputs
//   test_overlay/rate/delay : configuration driven to the generator
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   res               : result handshake (master side)
module filter_test_seq
  import filter_test_seq_pkg::*;
#(
  parameter int NUM_STEPS      = FILTER_SEQ_STEPS,
  parameter int SETTLE_CYCLES  = FILTER_SEQ_SETTLE,
  parameter int MEASURE_CYCLES = FILTER_SEQ_MEASURE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0]    wr_addr,
  input  logic [SIZE_DELAY+1:0]           wr_data,
  input  logic                            start,
  input  logic [$clog2(NUM_STEPS):0]      run_steps,
  input  logic                            abort,
  input  logic [2:0]                      filter_sel,
  input  logic [6*SIZE_FILTER_DATA-1:0]   filter_data,
  output logic                            test_overlay,
  output logic                            test_rate,
  output logic [SIZE_DELAY-1:0]           test_delay,
  output logic                            busy,
  output logic                            done,
  filter_test_seq_if.master               res
);

  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam int CNT_W  = $clog2(max_int(SETTLE_CYCLES, MEASURE_CYCLES) + 1);

  seq_state_t                     state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [STEP_W-1:0]              step_q, step_d;
  logic [STEP_W-1:0]              last_q, last_d;
  logic [2:0]                     sel_q, sel_d;
  test_cfg_t                      cfg_q, cfg_d;
  logic                           done_q, done_d;

  logic                           tbl_we;
  logic                           peak_clr, peak_en;
  logic signed [SIZE_FILTER_DATA-1:0] sel_data;
  logic signed [SIZE_FILTER_DATA-1:0] peak;
  logic                           start_ok;

  // NOTE: the table has no reset so it can map onto distributed RAM; its power-up contents are don't-care.
  test_cfg_t table_q [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      table_q[wr_addr] <= test_cfg_t'(wr_data);
    end
  end

  // Output select; codes outside 1..6 fall back to v1 (lane 0).
  always_comb begin
    sel_data = filter_data[0 +: SIZE_FILTER_DATA];
    for (int i = 2; i <= 6; i++) begin
      if (sel_q == 3'(i)) begin
        sel_data = filter_data[(i-1)*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
      end
    end
  end

  assign start_ok = start && (run_steps != '0) &&
                    (run_steps <= (STEP_W+1)'(NUM_STEPS));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    last_d   = last_q;
    sel_d    = sel_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    tbl_we   = 1'b0;
    peak_clr = 1'b0;
    peak_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cfg_d  = '0;
        tbl_we = wr_en;
        if (start_ok) begin
          step_d  = '0;
          last_d  = STEP_W'(run_steps - 1'b1);
          sel_d   = filter_sel;
          cfg_d   = table_q[0];
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d    = '0;
          peak_clr = 1'b1;
          state_d  = MEASURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        // The final sample is folded in on the same edge that enters REPORT.
        peak_en = 1'b1;
        if (cnt_q == CNT_W'(MEASURE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = REPORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPORT: begin
        if (res.res_ready) begin
          if (step_q == last_q) begin
            cfg_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            step_d  = step_q + 1'b1;
            cfg_d   = table_q[step_q + 1'b1];
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition above and drops any pending result.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      cfg_d    = '0;
      cnt_d    = '0;
      done_d   = 1'b1;
      peak_clr = 1'b0;
      peak_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      last_q  <= '0;
      sel_q   <= '0;
      cfg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
    end
  end

  filter_seq_peak #(.DATA_W(SIZE_FILTER_DATA)) u_peak (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (peak_clr),
    .en_i   (peak_en),
    .data_i (sel_data),
    .peak_o (peak)
  );

  assign test_overlay  = cfg_q.overlay;
  assign test_rate     = cfg_q.rate;
  assign test_delay    = cfg_q.delay;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign res.res_valid = (state_q == REPORT);
  assign res.res_step  = step_q;
  assign res.res_peak  = peak;

endmodule

// File: doc/filter_test_seq.md
# filter_test_seq

Sequencer for the filter test bench-in-FPGA. It steps the exponential signal generator through a programmed table of test configurations (overlay, rate, delay), one per step. For each step it holds the configuration for a settle window, then records the signed peak of a selected filter output over a measure window and reports it through a valid/ready handshake. It sits in the filter top level, between the control interface and the generator's test_overlay/test_rate/test_delay inputs, and observes the filter outputs.

## Interface
- NUM_STEPS, 8, depth of configuration table (power of 2, ≥2)
- SETTLE_CYCLES, 64, cycles held before measuring (≥1)
- MEASURE_CYCLES, 256, samples per measure window (≥1)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  table write strobe (accepted only in IDLE)
- wr_addr  in  $clog2(NUM_STEPS)  table entry index
- wr_data  in  SIZE_DELAY+2  {overlay, rate, delay[SIZE_DELAY-1:0]}
- start  in  1  one-cycle pulse; begins a run (IDLE only)
- run_steps  in  $clog2(NUM_STEPS)+1  steps to run, sampled on start; 0 or >NUM_STEPS → start ignored
- abort  in  1  terminate run
- filter_sel  in  3  output to measure: 1..6 = output_data_v1..v6, other values → v1
- filter_data  in  6×SIZE_FILTER_DATA  packed v6..v1, signed
- test_overlay  out  1  to generator
- test_rate  out  1  to generator
- test_delay  out  SIZE_DELAY  to generator
- busy  out  1  high from start accept until return to IDLE
- done  out  1  one-cycle pulse after last step reported or abort
- res_valid / res_ready  out/in  1  result handshake
- res_step  out  $clog2(NUM_STEPS)  step index of result
- res_peak  out  SIZE_FILTER_DATA  signed max over measure window

## Operation
- States: IDLE, SETTLE, MEASURE, REPORT.
- IDLE: test outputs 0; wr_en writes table[wr_addr]. Valid start → step=0, load table[0] onto test outputs, enter SETTLE.
- SETTLE: counter runs for SETTLE_CYCLES cycles, then → MEASURE with peak preset to the most negative value (1 followed by zeros).
- MEASURE: every cycle, peak ← max(peak, selected filter_data), signed compare. filter_sel is sampled on start and held for the run. After MEASURE_CYCLES samples → REPORT.
- REPORT: res_valid=1 with step/peak stable until res_valid&res_ready.
  - On handshake, if step==run_steps-1 → IDLE with done pulse.
  - Otherwise step+1, load next entry, → SETTLE.
- abort, in any non-IDLE state, takes priority over all other transitions. Next cycle the block is IDLE, with done=1 for one cycle, res_valid=0 and test outputs 0. A pending result is discarded.
- start while busy: ignored. wr_en while busy: ignored; the table is unchanged.
- The table is not cleared by reset; entry contents after power-up are undefined.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Start accepted at edge N: busy and test outputs valid from N+1.
- First sample is taken at cycle N+1+SETTLE_CYCLES.
- res_valid rises at cycle N+1+SETTLE_CYCLES+MEASURE_CYCLES.
- Handshake at edge M: the next step's config appears at M+1, or done=1 at M+1 with busy=0 the same cycle.
- The last sample compares in the same cycle as the MEASURE→REPORT transition. There is no extra latency.
- Reset asserted mid-run: immediate return to IDLE, no done pulse.

## Structure
- package_settings gains:
  - typedef test_cfg_t struct packed {overlay, rate, delay}
  - typedef seq_state_t enum {IDLE, SETTLE, MEASURE, REPORT}
  - defaults FILTER_SEQ_SETTLE and FILTER_SEQ_MEASURE
- Sub-module filter_seq_peak: signed running-max accumulator with clear/enable.

## Test plan
- Write 3 entries: {0,0,5}, {1,0,10}, {0,1,20}. Pulse start with run_steps=3, res_ready=1.
  - Required: three results with res_step 0,1,2; test_delay 5→10→20 at the documented cycles; done after the third result.
- Force selected filter_data = −7 constant during MEASURE → res_peak = −7. Inject a single +300 on sample MEASURE_CYCLES-1 → res_peak = 300.
- Hold res_ready=0 for 50 cycles in REPORT → res_valid, res_step and res_peak stable, test outputs unchanged. Raise res_ready → the next step starts the following cycle.
- Assert abort in the 10th MEASURE cycle → IDLE next cycle, done=1 for one cycle, no res_valid. A subsequent start runs normally.
- start with run_steps=0, and start while busy → no effect. wr_en while busy → table unchanged on a rerun.
- Assert reset low mid-SETTLE → all outputs 0 asynchronously, and IDLE after release.
